// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter that shares one register-block bus
// between NUM_REQ requesters. A grant latches the winner's request fields,
// pulses bus_req for one cycle, waits for bus_ready/bus_err (or the watchdog),
// then returns a one-cycle ack with error flag and read data to the winner.
module reg_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  localparam int BW        = DATA_WIDTH / 8,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               m_req,
  input  logic [NUM_REQ-1:0]               m_req_is_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    m_wr_data,
  input  logic [NUM_REQ*BW-1:0]            m_wr_biten,
  output logic [NUM_REQ-1:0]               m_ack,
  output logic                             m_err,
  output logic [DATA_WIDTH-1:0]            m_rd_data,
  output logic                             bus_req,
  output logic                             bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]            bus_addr,
  output logic [DATA_WIDTH-1:0]            bus_wr_data,
  output logic [BW-1:0]                    bus_wr_biten,
  input  logic                             bus_ready,
  input  logic                             bus_err,
  input  logic [DATA_WIDTH-1:0]            bus_rd_data,
  output logic                             busy,
  output logic [GW-1:0]                    grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Counter only needs to reach TIMEOUT-1 before the watchdog fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GW-1:0]          r_last;
  logic [GW-1:0]          r_gnt;
  logic                   r_bus_req;
  logic                   r_bus_wr;
  logic [ADDR_WIDTH-1:0]  r_bus_addr;
  logic [DATA_WIDTH-1:0]  r_bus_wdata;
  logic [BW-1:0]          r_bus_biten;
  logic [NUM_REQ-1:0]     r_ack;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [CNT_W-1:0]       r_cnt;

  logic [GW-1:0]          w_pick;
  logic [GW-1:0]          w_idx;
  logic                   w_found;
  logic                   w_resp;
  logic                   w_timeout;
  logic [NUM_REQ-1:0]     w_gnt_onehot;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [BW-1:0]          w_sel_biten;

  // Round-robin pick: first requesting index after the last winner, wrapping.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = GW'((int'(r_last) + off) % NUM_REQ);
      if (!w_found && m_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Field mux for the candidate winner; only sampled in the grant cycle.
  always_comb begin
    w_sel_addr  = m_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel_wdata = m_wr_data[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_biten = m_wr_biten[int'(w_pick)*BW +: BW];
  end

  // Completion and watchdog decode. The bus_req issue cycle is not counted,
  // so a hung access is ended TIMEOUT cycles after the issue cycle and the
  // ack lands TIMEOUT+1 cycles after bus_req.
  assign w_resp       = bus_ready | bus_err;
  assign w_timeout    = (TIMEOUT != 0) && !r_bus_req && (r_cnt == CNT_LIMIT);
  assign w_gnt_onehot = NUM_REQ'(1) << r_gnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a response in the timeout cycle still completes normally.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_resp || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: grant latch, bus_req pulse, response capture, ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= GW'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_biten <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_cnt       <= '0;
    end else begin
      r_bus_req <= 1'b0;
      r_ack     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_bus_req   <= 1'b1;
            r_gnt       <= w_pick;
            r_bus_wr    <= m_req_is_wr[w_pick];
            r_bus_addr  <= w_sel_addr;
            r_bus_wdata <= w_sel_wdata;
            r_bus_biten <= w_sel_biten;
            r_cnt       <= '0;
          end
        end
        S_WAIT: begin
          if (w_resp) begin
            r_err   <= bus_err;
            r_rdata <= bus_rd_data;
            r_ack   <= w_gnt_onehot;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_ack   <= w_gnt_onehot;
          end else if (!r_bus_req) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_last <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy = (r_state == S_WAIT) || (r_state == S_RESP);
  end

  assign m_ack         = r_ack;
  assign m_err         = r_err;
  assign m_rd_data     = r_rdata;
  assign bus_req       = r_bus_req;
  assign bus_req_is_wr = r_bus_wr;
  assign bus_addr      = r_bus_addr;
  assign bus_wr_data   = r_bus_wdata;
  assign bus_wr_biten  = r_bus_biten;
  assign grant_id      = r_gnt;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed vector table, hand-written reset and
// stray-response sequences, then randomized transactions against a model.
module tb_reg_bus_arbiter;

  localparam int NR = 2;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     m_req = '0;
  logic [NR-1:0]     m_req_is_wr;
  logic [NR*AW-1:0]  m_addr;
  logic [NR*DW-1:0]  m_wr_data;
  logic [NR*BW-1:0]  m_wr_biten;
  logic [NR-1:0]     m_ack;
  logic              m_err;
  logic [DW-1:0]     m_rd_data;
  logic              bus_req;
  logic              bus_req_is_wr;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wr_data;
  logic [BW-1:0]     bus_wr_biten;
  logic              bus_ready = 1'b0;
  logic              bus_err = 1'b0;
  logic [DW-1:0]     bus_rd_data = '0;
  logic              busy;
  logic [0:0]        grant_id;

  logic          f_wr    [NR];
  logic [AW-1:0] f_addr  [NR];
  logic [DW-1:0] f_wdata [NR];
  logic [BW-1:0] f_biten [NR];

  int errors = 0;
  int checks = 0;

  reg_bus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_req_is_wr(m_req_is_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_biten(m_wr_biten),
    .m_ack(m_ack), .m_err(m_err), .m_rd_data(m_rd_data),
    .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_req_is_wr = '0;
    m_addr      = '0;
    m_wr_data   = '0;
    m_wr_biten  = '0;
    for (int i = 0; i < NR; i++) begin
      m_req_is_wr[i]          = f_wr[i];
      m_addr[i*AW +: AW]      = f_addr[i];
      m_wr_data[i*DW +: DW]   = f_wdata[i];
      m_wr_biten[i*BW +: BW]  = f_biten[i];
    end
  end

  typedef struct {
    logic [1:0]  mask;
    logic        wr0, wr1;
    logic [2:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  b0, b1;
    int          delay;     // response cycle relative to the bus_req cycle; -1 = never
    bit          use_err;
    logic [31:0] rdata;
    int          exp_gnt;
    int          exp_lat;   // cycles from bus_req to m_ack
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] mask, input logic wr0, input logic [2:0] a0,
                              input logic [31:0] d0, input logic [3:0] b0, input logic wr1,
                              input logic [2:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                              input int delay, input bit use_err, input logic [31:0] rdata,
                              input int exp_gnt, input int exp_lat, input bit exp_err,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.mask = mask; v.wr0 = wr0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
    v.wr1 = wr1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
    v.delay = delay; v.use_err = use_err; v.rdata = rdata;
    v.exp_gnt = exp_gnt; v.exp_lat = exp_lat; v.exp_err = exp_err; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from request to ack and compares against v's expectations.
  task automatic run_txn(input vec_t v, input string name);
    int n;
    int c;
    bit extra;
    logic          ex_wr;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic [BW-1:0] ex_biten;
    f_wr[0] = v.wr0; f_addr[0] = v.a0; f_wdata[0] = v.d0; f_biten[0] = v.b0;
    f_wr[1] = v.wr1; f_addr[1] = v.a1; f_wdata[1] = v.d1; f_biten[1] = v.b1;
    ex_wr    = f_wr[v.exp_gnt];
    ex_addr  = f_addr[v.exp_gnt];
    ex_wdata = f_wdata[v.exp_gnt];
    ex_biten = f_biten[v.exp_gnt];
    m_req = v.mask;
    bus_ready = 1'b0;
    bus_err = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_req && n < 8);
    chk({name, " req_to_bus_req"}, 64'(n), 64'(1));
    chk({name, " grant_id"}, 64'(grant_id), 64'(v.exp_gnt));
    chk({name, " busy_wait"}, 64'(busy), 64'(1));
    chk({name, " bus_is_wr"}, 64'(bus_req_is_wr), 64'(ex_wr));
    chk({name, " bus_addr"}, 64'(bus_addr), 64'(ex_addr));
    chk({name, " bus_wr_data"}, 64'(bus_wr_data), 64'(ex_wdata));
    chk({name, " bus_wr_biten"}, 64'(bus_wr_biten), 64'(ex_biten));
    // Requester fields may change after the grant; the bus must not follow.
    for (int i = 0; i < NR; i++) begin
      f_wr[i] = 1'($urandom); f_addr[i] = AW'($urandom);
      f_wdata[i] = $urandom; f_biten[i] = BW'($urandom);
    end
    c = 0;
    extra = 1'b0;
    while (c < 40) begin
      if (c == v.delay) begin
        bus_ready = !v.use_err;
        bus_err = v.use_err;
        bus_rd_data = v.rdata;
      end else begin
        bus_ready = 1'b0;
        bus_err = 1'b0;
        bus_rd_data = $urandom;
      end
      tick();
      c++;
      bus_ready = 1'b0;
      bus_err = 1'b0;
      if (bus_req) extra = 1'b1;
      if (m_ack != '0) break;
    end
    chk({name, " ack_latency"}, 64'(c), 64'(v.exp_lat));
    chk({name, " m_ack"}, 64'(m_ack), 64'(1) << v.exp_gnt);
    chk({name, " m_err"}, 64'(m_err), 64'(v.exp_err));
    chk({name, " m_rd_data"}, 64'(m_rd_data), 64'(v.exp_rd));
    chk({name, " bus_req_width"}, 64'(extra), 64'(0));
    chk({name, " bus_addr_held"}, 64'(bus_addr), 64'(ex_addr));
    chk({name, " bus_wdata_held"}, 64'(bus_wr_data), 64'(ex_wdata));
    m_req = v.mask & ~(2'(1) << v.exp_gnt);
    tick();
    chk({name, " ack_one_cycle"}, 64'(m_ack), 64'(0));
    chk({name, " rd_data_held"}, 64'(m_rd_data), 64'(v.exp_rd));
    chk({name, " busy_idle"}, 64'(busy), 64'(0));
  endtask

  // Reference rules: round-robin choice and response/watchdog outcome.
  function automatic int rr_pick(input logic [1:0] mask, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  vec_t tbl [10];
  vec_t v;
  int   mlast;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      f_wr[i] = 1'b0; f_addr[i] = '0; f_wdata[i] = '0; f_biten[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset bus_req", 64'(bus_req), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("reset m_ack", 64'(m_ack), 64'(0));
    chk("reset m_err", 64'(m_err), 64'(0));
    chk("reset m_rd_data", 64'(m_rd_data), 64'(0));
    chk("reset grant_id", 64'(grant_id), 64'(0));
    chk("reset bus_addr", 64'(bus_addr), 64'(0));
    chk("reset bus_wr_data", 64'(bus_wr_data), 64'(0));

    //             mask  wr0 a0  d0            b0    wr1 a1  d1            b1    dly use_err rdata      gnt lat err exp_rd
    tbl[0] = mk(2'b01, 1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        4'h0, 0,  0, 32'h00000055, 0, 1,  0, 32'h00000055);
    tbl[1] = mk(2'b10, 0, 0, 32'h0,        4'h0, 0, 5, 32'h0,        4'h0, 4,  0, 32'h12345678, 1, 5,  0, 32'h12345678);
    tbl[2] = mk(2'b11, 1, 1, 32'h11111111, 4'h3, 0, 2, 32'h22222222, 4'hC, 0,  0, 32'hA0000001, 0, 1,  0, 32'hA0000001);
    tbl[3] = mk(2'b11, 1, 1, 32'h11111111, 4'h3, 0, 2, 32'h22222222, 4'hC, 1,  0, 32'hA0000002, 1, 2,  0, 32'hA0000002);
    tbl[4] = mk(2'b11, 0, 6, 32'h33333333, 4'h1, 1, 7, 32'h44444444, 4'h8, 2,  0, 32'hA0000003, 0, 3,  0, 32'hA0000003);
    tbl[5] = mk(2'b11, 0, 6, 32'h33333333, 4'h1, 1, 7, 32'h44444444, 4'h8, 0,  0, 32'hA0000004, 1, 1,  0, 32'hA0000004);
    tbl[6] = mk(2'b01, 0, 4, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, -1, 0, 32'h0,        0, 17, 1, 32'h0);
    tbl[7] = mk(2'b10, 0, 0, 32'h0,        4'h0, 0, 1, 32'h0,        4'h0, 16, 0, 32'hCAFEF00D, 1, 17, 0, 32'hCAFEF00D);
    tbl[8] = mk(2'b10, 0, 0, 32'h0,        4'h0, 1, 2, 32'h5A5A5A5A, 4'h6, 15, 0, 32'h0BADF00D, 1, 16, 0, 32'h0BADF00D);
    tbl[9] = mk(2'b01, 1, 7, 32'h76543210, 4'h9, 0, 0, 32'h0,        4'h0, 2,  1, 32'hBAD00001, 0, 3,  1, 32'hBAD00001);
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Stray responses while idle must be ignored.
    m_req = '0;
    for (int i = 0; i < 4; i++) begin
      bus_ready = i[0];
      bus_err = !i[0];
      bus_rd_data = $urandom;
      tick();
      chk($sformatf("stray%0d m_ack", i), 64'(m_ack), 64'(0));
      chk($sformatf("stray%0d busy", i), 64'(busy), 64'(0));
    end
    bus_ready = 1'b0;
    bus_err = 1'b0;
    chk("stray m_rd_data", 64'(m_rd_data), 64'(32'hBAD00001));

    // Reset in the middle of a WAIT: requester 1 granted, then reset wipes it.
    f_addr[1] = 3'd6; f_wdata[1] = 32'h600DD00D; f_biten[1] = 4'hF; f_wr[1] = 1'b1;
    m_req = 2'b10;
    tick();
    chk("midrst bus_req", 64'(bus_req), 64'(1));
    chk("midrst grant", 64'(grant_id), 64'(1));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst grant_id", 64'(grant_id), 64'(0));
    chk("midrst bus_addr", 64'(bus_addr), 64'(0));
    chk("midrst bus_wr_data", 64'(bus_wr_data), 64'(0));
    chk("midrst bus_is_wr", 64'(bus_req_is_wr), 64'(0));
    chk("midrst m_err", 64'(m_err), 64'(0));
    chk("midrst m_rd_data", 64'(m_rd_data), 64'(0));
    m_req = '0;
    tick();
    chk("midrst m_ack", 64'(m_ack), 64'(0));
    rst_n = 1'b1;
    tick();
    v = mk(2'b11, 0, 1, 32'h0, 4'h1, 0, 2, 32'h0, 4'h2, 1, 0, 32'h00C0FFEE, 0, 2, 0, 32'h00C0FFEE);
    run_txn(v, "postrst0");
    v = mk(2'b11, 0, 1, 32'h0, 4'h1, 0, 2, 32'h0, 4'h2, 0, 0, 32'h00BEEF00, 1, 1, 0, 32'h00BEEF00);
    run_txn(v, "postrst1");

    // Randomized transactions against the reference rules.
    mlast = 1;
    for (int t = 0; t < 40; t++) begin
      int d;
      bit in_time;
      v.mask = 2'($urandom_range(1, 3));
      v.wr0 = 1'($urandom); v.a0 = 3'($urandom); v.d0 = $urandom; v.b0 = 4'($urandom);
      v.wr1 = 1'($urandom); v.a1 = 3'($urandom); v.d1 = $urandom; v.b1 = 4'($urandom);
      d = int'($urandom_range(0, 20));
      v.delay = d;
      v.use_err = ($urandom_range(0, 3) == 0);
      v.rdata = $urandom;
      in_time = (d <= TO);
      v.exp_gnt = rr_pick(v.mask, mlast);
      v.exp_lat = in_time ? d + 1 : TO + 1;
      v.exp_err = in_time ? v.use_err : 1'b1;
      v.exp_rd = in_time ? v.rdata : 32'h0;
      run_txn(v, $sformatf("rnd%0d", t));
      mlast = v.exp_gnt;
    end

    m_req = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
